// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND scan controller.
// Digit geometry, scan FSM encoding and polarity helpers.
package fnd_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int DIGIT_W    = 4;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } scan_state_t;

  // Idle level of the common lines for a given polarity
  function automatic logic [NUM_DIGITS-1:0] com_off(input bit act_low);
    return act_low ? '1 : '0;
  endfunction

  // Idle level of the decimal point for a given polarity
  function automatic logic dp_off(input bit act_low);
    return act_low;
  endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// Digit/mask inputs and display-side outputs of the scan controller.
// The master side supplies digits; the slave side is the controller.
interface fnd_scan_ctrl_if;
  import fnd_pkg::*;

  logic                          i_en;
  logic [NUM_DIGITS*DIGIT_W-1:0] i_digits;
  logic [NUM_DIGITS-1:0]         i_dp_mask;
  logic [NUM_DIGITS-1:0]         i_blank_mask;
  logic [NUM_DIGITS-1:0]         o_com;
  logic [DIGIT_W-1:0]            o_num;
  logic                          o_dp;
  logic                          o_frame_done;

  modport master (
    output i_en, i_digits, i_dp_mask, i_blank_mask,
    input  o_com, o_num, o_dp, o_frame_done
  );

  modport slave (
    input  i_en, i_digits, i_dp_mask, i_blank_mask,
    output o_com, o_num, o_dp, o_frame_done
  );

endinterface

// File: rtl/fnd_prescaler.sv
// Modulo-N counter with enable, synchronous clear and terminal count.
// cnt_nxt exposes the value the counter takes at the next edge.
module fnd_prescaler #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt,
  output logic         tc
);

  // Terminal count and next count value
  always_comb begin
    tc      = (cnt == W'(N-1));
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (en) begin
      cnt_nxt = tc ? '0 : cnt + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Six-digit time-multiplexed FND scan controller.
// Outputs are registered from next-state values so they align with the FSM.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int BLANK_CYC   = 2,
  parameter int COM_ACT_LOW = 1,
  parameter int DP_ACT_LOW  = 1
) (
  input  logic           clk,
  input  logic           rst,
  fnd_scan_ctrl_if.slave bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int SW = NUM_DIGITS * DIGIT_W;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS-1);
  localparam logic [NUM_DIGITS-1:0] COM_OFF = com_off(COM_ACT_LOW != 0);
  localparam logic DP_OFF = dp_off(DP_ACT_LOW != 0);

  scan_state_t           state_q, state_n;
  logic [IW-1:0]         idx_q, idx_n;
  logic [SW-1:0]         dig_q, dig_n;
  logic [NUM_DIGITS-1:0] dpm_q, dpm_n;
  logic [NUM_DIGITS-1:0] blm_q, blm_n;

  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  tc, pre_clr, pre_en;

  logic [NUM_DIGITS-1:0] com_q, com_n;
  logic [DIGIT_W-1:0]    num_q, num_n;
  logic                  dp_q, dp_n;
  logic                  fd_q, fd_n;

  fnd_prescaler #(
    .N(SCAN_DIV),
    .W(CW)
  ) u_pre (
    .clk    (clk),
    .rst    (rst),
    .clr    (pre_clr),
    .en     (pre_en),
    .cnt    (cnt),
    .cnt_nxt(cnt_nxt),
    .tc     (tc)
  );

  // Scan FSM: slot sequencing, digit index and frame snapshot
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    dig_n   = dig_q;
    dpm_n   = dpm_q;
    blm_n   = blm_q;
    pre_clr = 1'b0;
    pre_en  = 1'b0;
    if (!bus.i_en) begin
      state_n = IDLE;
      idx_n   = '0;
      pre_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_n = BLANK;
          idx_n   = '0;
          pre_clr = 1'b1;
          dig_n   = bus.i_digits;
          dpm_n   = bus.i_dp_mask;
          blm_n   = bus.i_blank_mask;
        end
        BLANK, DRIVE: begin
          pre_en = 1'b1;
          if (tc) begin
            state_n = BLANK;
            if (idx_q == LAST) begin
              idx_n = '0;
              dig_n = bus.i_digits;
              dpm_n = bus.i_dp_mask;
              blm_n = bus.i_blank_mask;
            end else begin
              idx_n = idx_q + 1'b1;
            end
          end else if (state_q == BLANK &&
                       cnt == CW'(BLANK_CYC-1)) begin
            state_n = DRIVE;
          end
        end
        default: begin
          state_n = IDLE;
          idx_n   = '0;
          pre_clr = 1'b1;
        end
      endcase
    end
  end

  // Output values for the upcoming cycle
  always_comb begin
    com_n = COM_OFF;
    num_n = '0;
    dp_n  = DP_OFF;
    fd_n  = 1'b0;
    if (state_n != IDLE) begin
      num_n = dig_n[idx_n*DIGIT_W +: DIGIT_W];
      fd_n  = (cnt_nxt == CW'(SCAN_DIV-1)) && (idx_n == LAST);
      if (state_n == DRIVE) begin
        if (!blm_n[idx_n]) begin
          com_n = COM_OFF ^ (NUM_DIGITS'(1) << idx_n);
        end
        dp_n = DP_OFF ^ dpm_n[idx_n];
      end
    end
  end

  // State, snapshot and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dig_q   <= '0;
      dpm_q   <= '0;
      blm_q   <= '0;
      com_q   <= COM_OFF;
      num_q   <= '0;
      dp_q    <= DP_OFF;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      dig_q   <= dig_n;
      dpm_q   <= dpm_n;
      blm_q   <= blm_n;
      com_q   <= com_n;
      num_q   <= num_n;
      dp_q    <= dp_n;
      fd_q    <= fd_n;
    end
  end

  assign bus.o_com        = com_q;
  assign bus.o_num        = num_q;
  assign bus.o_dp         = dp_q;
  assign bus.o_frame_done = fd_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed testbench for fnd_scan_ctrl.
// SCAN_DIV=8, BLANK_CYC=2, active-low commons and decimal point.
module tb_fnd_scan_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;
  int   onehot_err = 0;

  logic [23:0] nx_dig;
  logic [5:0]  nx_dp;
  logic [5:0]  nx_bl;

  fnd_scan_ctrl_if bus ();

  fnd_scan_ctrl #(
    .SCAN_DIV   (8),
    .BLANK_CYC  (2),
    .COM_ACT_LOW(1),
    .DP_ACT_LOW (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Track any cycle with more than one common active
  always @(negedge clk) begin
    if (!$onehot0(~bus.o_com)) onehot_err++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_com"}, 32'(bus.o_com), 32'h3f);
    chk({tag, "_num"}, 32'(bus.o_num), 32'h0);
    chk({tag, "_dp"},  32'(bus.o_dp), 32'h1);
    chk({tag, "_fd"},  32'(bus.o_frame_done), 32'h0);
  endtask

  // Checks one full frame starting at slot 0 cycle 0.
  task automatic frame(input logic [23:0] ed, input logic [5:0] dm,
                       input logic [5:0] bm, input bit mid);
    logic [5:0] ec;
    logic [3:0] en;
    logic       edp, efd;
    string      t;
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 8; j++) begin
        ec  = (j < 2 || bm[k]) ? 6'h3f : ~(6'd1 << k);
        en  = ed[4*k +: 4];
        edp = !(j >= 2 && dm[k]);
        efd = (k == 5 && j == 7);
        t = $sformatf("k%0d_j%0d", k, j);
        chk({"com_", t}, 32'(bus.o_com), 32'(ec));
        chk({"num_", t}, 32'(bus.o_num), 32'(en));
        chk({"dp_", t},  32'(bus.o_dp), 32'(edp));
        chk({"fd_", t},  32'(bus.o_frame_done), 32'(efd));
        if (mid && k == 3 && j == 3) bus.i_digits = 24'h999999;
        if (k == 5 && j == 7) begin
          bus.i_digits     = nx_dig;
          bus.i_dp_mask    = nx_dp;
          bus.i_blank_mask = nx_bl;
        end
        step();
      end
    end
  endtask

  initial begin
    int pulses;
    int coms;
    rst = 1'b1;
    bus.i_en = 1'b0;
    bus.i_digits = 24'h0;
    bus.i_dp_mask = 6'h0;
    bus.i_blank_mask = 6'h0;
    step();
    step();
    chk_reset("rst");

    rst = 1'b0;
    bus.i_en = 1'b1;
    bus.i_digits = 24'h543210;
    step();

    nx_dig = 24'h543210; nx_dp = 6'b000100; nx_bl = 6'b0;
    frame(24'h543210, 6'b0, 6'b0, 1'b0);
    nx_dig = 24'h543210; nx_dp = 6'b0; nx_bl = 6'b100001;
    frame(24'h543210, 6'b000100, 6'b0, 1'b0);
    nx_dig = 24'h543210; nx_dp = 6'b0; nx_bl = 6'b0;
    frame(24'h543210, 6'b0, 6'b100001, 1'b0);
    nx_dig = 24'h999999; nx_dp = 6'b0; nx_bl = 6'b0;
    frame(24'h543210, 6'b0, 6'b0, 1'b1);
    frame(24'h999999, 6'b0, 6'b0, 1'b0);

    for (int i = 0; i < 19; i++) step();
    chk("drv_s2_com", 32'(bus.o_com), 32'h3b);
    bus.i_en = 1'b0;
    step();
    chk("dis_com", 32'(bus.o_com), 32'h3f);
    chk("dis_dp", 32'(bus.o_dp), 32'h1);
    chk("dis_fd", 32'(bus.o_frame_done), 32'h0);
    pulses = 0;
    coms = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      pulses += int'(bus.o_frame_done);
      coms += int'(bus.o_com != 6'h3f);
    end
    chk("dis_no_fd", 32'(pulses), 32'h0);
    chk("dis_no_com", 32'(coms), 32'h0);

    bus.i_en = 1'b1;
    bus.i_digits = 24'h543210;
    nx_dig = 24'h543210;
    step();
    frame(24'h543210, 6'b0, 6'b0, 1'b0);

    for (int i = 0; i < 35; i++) step();
    chk("mid_s4_com", 32'(bus.o_com), 32'h2f);
    rst = 1'b1;
    step();
    chk_reset("mid_rst");
    rst = 1'b0;
    step();
    frame(24'h543210, 6'b0, 6'b0, 1'b0);

    chk("onehot_all", 32'(onehot_err), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
